// File: rtl/pio_result_tx.sv
// Result FIFO feeding an HPS PIO via a req/ack toggle handshake.
// Define PIO_RESULT_TX_ACK_SYNC_EN to add a two-flop synchronizer on pio_ack_in.
module pio_result_tx #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        pio_data_out,
  output logic                     pio_req_out,
  input  logic                     pio_ack_in,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, WAIT_ACK} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              req_q, req_d;
  logic              err_q, err_d;
  logic              ack_prev_q, ack_prev_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              ack_s;
  logic              push;
  logic              pop;

`ifdef PIO_RESULT_TX_ACK_SYNC_EN
  logic ack_meta_q;
  logic ack_sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_meta_q <= 1'b0;
      ack_sync_q <= 1'b0;
    end else begin
      ack_meta_q <= pio_ack_in;
      ack_sync_q <= ack_meta_q;
    end
  end

  assign ack_s = ack_sync_q;
`else
  assign ack_s = pio_ack_in;
`endif

  assign in_ready     = (count_q != CW'(DEPTH));
  assign pio_data_out = data_q;
  assign pio_req_out  = req_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q == WAIT_ACK);
  assign proto_err    = err_q;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    req_d      = req_q;
    err_d      = err_q;
    ack_prev_d = ack_s;
    push       = in_valid && in_ready;
    pop        = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          data_d  = mem_q[rd_ptr_q];
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Any ack movement while nothing is outstanding is a handshake violation.
    if ((state_q == IDLE) && (ack_s != ack_prev_q)) err_d = 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_q     <= '0;
      req_q      <= 1'b0;
      err_q      <= 1'b0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_q     <= data_d;
      req_q      <= req_d;
      err_q      <= err_d;
      ack_prev_q <= ack_prev_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_pio_result_tx.sv
// Self-checking bench for pio_result_tx: directed handshake scenarios plus
// randomized traffic scored against an in-order queue model of the FIFO.
module tb_pio_result_tx;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
`ifdef PIO_RESULT_TX_ACK_SYNC_EN
  localparam int ACK_LAT = 3;
`else
  localparam int ACK_LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pio_data_out;
  logic              pio_req_out;
  logic              pio_ack_in;
  logic [3:0]        fifo_count;
  logic              busy;
  logic              proto_err;

  int errors = 0;
  int checks = 0;
  logic [31:0] model_q[$];
  logic [31:0] rx_q[$];

  always #5 clk = ~clk;

  pio_result_tx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pio_data_out (pio_data_out),
    .pio_req_out  (pio_req_out),
    .pio_ack_in   (pio_ack_in),
    .fifo_count   (fifo_count),
    .busy         (busy),
    .proto_err    (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    int n = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_ready_timeout: in_ready=%b expected 1", in_ready);
    end
    tick();
    model_q.push_back(w);
    in_valid = 1'b0;
  endtask

  // HPS-side responder: reads each newly presented word and acks it at once.
  task automatic drain(input int n);
    int   cyc = 0;
    logic pushing;
    while ((rx_q.size() < n || busy) && cyc < 400) begin
      if (pio_req_out != pio_ack_in) begin
        rx_q.push_back(pio_data_out);
        pio_ack_in = pio_req_out;
      end
      pushing = in_valid && in_ready;
      tick();
      cyc++;
      if (pushing) begin
        model_q.push_back(in_data);
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    pio_ack_in = 1'b0;
    #2;
    checks++; if (pio_data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got=%h exp=%h", pio_data_out, 32'h0); end
    checks++; if (pio_req_out !== 1'b0) begin errors++; $display("FAIL reset_req: got=%b exp=0", pio_req_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got=%b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got=%0d exp=0", fifo_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got=%b exp=0", proto_err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got=%b exp=1", in_ready); end
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    in_data  = 32'hDEADBEEF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL lat_count_t: got=%0d exp=1", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_t: got=%b exp=0", busy); end
    tick();
    checks++; if (pio_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL lat_data: got=%h exp=deadbeef", pio_data_out); end
    checks++; if (pio_req_out !== 1'b1) begin errors++; $display("FAIL lat_req: got=%b exp=1", pio_req_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got=%b exp=1", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL lat_count: got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_ack();
    logic exp_busy;
    pio_ack_in = 1'b1;
    for (int k = 1; k <= ACK_LAT; k++) begin
      tick();
      exp_busy = (k < ACK_LAT);
      checks++;
      if (busy !== exp_busy) begin errors++; $display("FAIL ack_busy_edge%0d: got=%b exp=%b", k, busy, exp_busy); end
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ack_err: got=%b exp=0", proto_err); end
    repeat (3) tick();
    checks++; if (pio_data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL ack_hold_data: got=%h exp=deadbeef", pio_data_out); end
    checks++; if (pio_req_out !== 1'b1) begin errors++; $display("FAIL ack_hold_req: got=%b exp=1", pio_req_out); end
    model_q.delete();
  endtask

  task automatic test_fill();
    logic [31:0] exp;
    model_q.delete();
    rx_q.delete();
    for (int i = 1; i <= 9; i++) push_word(i);
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_count: got=%0d exp=8", fifo_count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got=%b exp=0", in_ready); end
    in_data  = 32'd10;
    in_valid = 1'b1;
    repeat (3) tick();
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fill_stall_count: got=%0d exp=8", fifo_count); end
    checks++; if (pio_data_out !== 32'd1) begin errors++; $display("FAIL fill_head: got=%h exp=1", pio_data_out); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_stall_ready: got=%b exp=0", in_ready); end
    drain(10);
    checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL fill_rx_size: got=%0d exp=10", rx_q.size()); end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      exp = i + 1;
      checks++;
      if (rx_q[i] !== exp) begin errors++; $display("FAIL fill_order%0d: got=%h exp=%h", i, rx_q[i], exp); end
    end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL fill_empty: got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_push_pop();
    int n = 0;
    model_q.delete();
    rx_q.delete();
    push_word(32'hA0000001);
    push_word(32'hB0000002);
    push_word(32'hC0000003);
    push_word(32'hD0000004);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL pp_count_pre: got=%0d exp=3", fifo_count); end
    checks++; if (pio_data_out !== 32'hA0000001) begin errors++; $display("FAIL pp_head: got=%h exp=a0000001", pio_data_out); end
    pio_ack_in = pio_req_out;
    void'(model_q.pop_front());
    while (busy && n < 10) begin
      tick();
      n++;
    end
    checks++; if (n != ACK_LAT) begin errors++; $display("FAIL pp_ack_lat: got=%0d exp=%0d", n, ACK_LAT); end
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL pp_count_idle: got=%0d exp=3", fifo_count); end
    in_data  = 32'hE0000005;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    model_q.push_back(32'hE0000005);
    checks++; if (fifo_count !== 4'd3) begin errors++; $display("FAIL pp_count_same: got=%0d exp=3", fifo_count); end
    checks++; if (pio_data_out !== 32'hB0000002) begin errors++; $display("FAIL pp_next: got=%h exp=b0000002", pio_data_out); end
    drain(4);
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL pp_rx_size: got=%0d exp=4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size() && i < model_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== model_q[i]) begin errors++; $display("FAIL pp_order%0d: got=%h exp=%h", i, rx_q[i], model_q[i]); end
    end
  endtask

  task automatic test_proto_err();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL pe_clean: got=%b exp=0", proto_err); end
    pio_ack_in = ~pio_ack_in;
    repeat (ACK_LAT + 1) tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_set: got=%b exp=1", proto_err); end
    pio_ack_in = ~pio_ack_in;
    repeat (ACK_LAT + 1) tick();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_sticky: got=%b exp=1", proto_err); end
    rx_q.delete();
    model_q.delete();
    push_word(32'h5A5AA5A5);
    drain(1);
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL pe_rx_size: got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++;
      if (rx_q[0] !== 32'h5A5AA5A5) begin errors++; $display("FAIL pe_rx_data: got=%h exp=5a5aa5a5", rx_q[0]); end
    end
    checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL pe_after: got=%b exp=1", proto_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pe_busy: got=%b exp=0", busy); end
  endtask

  task automatic test_random();
    int          sent = 0;
    int          got = 0;
    int          cyc = 0;
    int          dly = 0;
    logic        pending = 1'b0;
    logic        pushing;
    logic [31:0] exp;
    model_q.delete();
    while ((got < 40 || busy) && cyc < 3000) begin
      if (!in_valid && sent < 40 && $urandom_range(0, 2) == 0) begin
        in_data  = $urandom;
        in_valid = 1'b1;
      end
      if (!pending && pio_req_out != pio_ack_in) begin
        checks++;
        if (model_q.size() == 0) begin
          errors++;
          $display("FAIL rnd_unexpected_word: got=%h exp=none", pio_data_out);
        end else begin
          exp = model_q.pop_front();
          if (pio_data_out !== exp) begin errors++; $display("FAIL rnd_word%0d: got=%h exp=%h", got, pio_data_out, exp); end
        end
        got++;
        pending = 1'b1;
        dly = $urandom_range(0, 4);
      end
      if (pending) begin
        if (dly == 0) begin
          pio_ack_in = pio_req_out;
          pending    = 1'b0;
        end else begin
          dly--;
        end
      end
      pushing = in_valid && in_ready;
      tick();
      cyc++;
      if (pushing) begin
        model_q.push_back(in_data);
        in_valid = 1'b0;
        sent++;
      end
    end
    checks++; if (got != 40) begin errors++; $display("FAIL rnd_count: got=%0d exp=40", got); end
    checks++; if (model_q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got=%0d exp=0", model_q.size()); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rnd_empty: got=%0d exp=0", fifo_count); end
  endtask

  task automatic test_reset_mid();
    rx_q.delete();
    model_q.delete();
    push_word(32'd11);
    push_word(32'd22);
    push_word(32'd33);
    push_word(32'd44);
    push_word(32'd55);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rm_busy_pre: got=%b exp=1", busy); end
    checks++; if (fifo_count !== 4'd4) begin errors++; $display("FAIL rm_count_pre: got=%0d exp=4", fifo_count); end
    reset      = 1'b1;
    pio_ack_in = 1'b0;
    #1;
    checks++; if (pio_data_out !== 32'h0) begin errors++; $display("FAIL rm_data: got=%h exp=0", pio_data_out); end
    checks++; if (pio_req_out !== 1'b0) begin errors++; $display("FAIL rm_req: got=%b exp=0", pio_req_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got=%b exp=0", busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rm_count: got=%0d exp=0", fifo_count); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rm_err: got=%b exp=0", proto_err); end
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_post_busy: got=%b exp=0", busy); end
    checks++; if (pio_req_out !== 1'b0) begin errors++; $display("FAIL rm_post_req: got=%b exp=0", pio_req_out); end
    checks++; if (pio_data_out !== 32'h0) begin errors++; $display("FAIL rm_post_data: got=%h exp=0", pio_data_out); end
    model_q.delete();
    push_word(32'd77);
    drain(1);
    checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL rm_rx_size: got=%0d exp=1", rx_q.size()); end
    if (rx_q.size() > 0) begin
      checks++;
      if (rx_q[0] !== 32'd77) begin errors++; $display("FAIL rm_rx_data: got=%h exp=4d", rx_q[0]); end
    end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rm_rx_err: got=%b exp=0", proto_err); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ack();
    test_fill();
    test_push_pop();
    test_proto_err();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
